// File: rtl/adc_fe_pkg.sv
// adc_fe_pkg: shared widths, data-format encoding and saturation limits for
// the ADC capture front-end (adc_capture_frontend / adc_fe_channel).
// Optional build macro used by the front-end: ADC_CAPTURE_FRONTEND_TESTPAT_EN.
package adc_fe_pkg;

  localparam int unsigned ADC_W_DEF    = 14;
  localparam int unsigned OUT_W_DEF    = 16;
  localparam int unsigned AVG_LOG2_MAX = 4;

  typedef enum logic {
    FMT_TWOS   = 1'b0,
    FMT_OFFBIN = 1'b1
  } fmt_e;

  // Largest positive value representable in a signed out_w-bit sample.
  function automatic int sat_max(input int unsigned out_w);
    return (1 << (out_w - 1)) - 1;
  endfunction

  // Most negative value representable in a signed out_w-bit sample.
  function automatic int sat_min(input int unsigned out_w);
    return -(1 << (out_w - 1));
  endfunction

endpackage

// File: rtl/adc_fe_channel.sv
// adc_fe_channel: one ADC channel of the capture front-end.
//   DCO synchroniser + rising-edge detect, input/hold registers,
//   S1 (format convert, sign-extend, offset subtract, saturate, sticky flag),
//   S2 (box-car accumulate / decimate by 2^AVG_LOG2, valid strobe).
// Ports:
//   clk, rst (async, active-low), enable, fmt_offset_bin, clear_flags
//   adc_d [ADC_W], adc_dco            raw data and its data clock
//   dc_offset [OUT_W]                 signed offset subtracted in S1
//   sample_out [OUT_W], sample_valid  averaged sample and one-cycle strobe
//   sat_flag                          sticky saturation flag
//   tp_sel (only with ADC_CAPTURE_FRONTEND_TESTPAT_EN) selects the ramp source
module adc_fe_channel
  import adc_fe_pkg::*;
#(
  parameter int unsigned ADC_W       = ADC_W_DEF,
  parameter int unsigned OUT_W       = OUT_W_DEF,
  parameter int unsigned AVG_LOG2    = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             fmt_offset_bin,
`ifdef ADC_CAPTURE_FRONTEND_TESTPAT_EN
  input  logic             tp_sel,
`endif
  input  logic [ADC_W-1:0] adc_d,
  input  logic             adc_dco,
  input  logic [OUT_W-1:0] dc_offset,
  input  logic             clear_flags,
  output logic [OUT_W-1:0] sample_out,
  output logic             sample_valid,
  output logic             sat_flag
);

  localparam int unsigned ACC_W = OUT_W + AVG_LOG2;
  localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic signed [OUT_W:0] SAT_HI = (OUT_W+1)'(sat_max(OUT_W));
  localparam logic signed [OUT_W:0] SAT_LO = (OUT_W+1)'(sat_min(OUT_W));
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   edge_c;
  logic                   accept;
  logic [ADC_W-1:0]       d_q;
  logic [ADC_W-1:0]       hold_q;
  logic                   hold_vld;
  logic                   hold_tp;
  logic [ADC_W-1:0]       load_d;
  logic                   load_tp;

  logic [ADC_W-1:0]        src;
  logic signed [OUT_W:0]   ext;
  logic signed [OUT_W:0]   diff;
  logic                    clamp_hi;
  logic                    clamp_lo;
  logic [OUT_W-1:0]        s1_d;
  logic [OUT_W-1:0]        s1_q;
  logic                    s1_vld;

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] s1_ext;
  logic signed [ACC_W-1:0] sum;
  logic [CNT_W-1:0]        cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      d_q    <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], adc_dco};
      hist_q <= sync_q[SYNC_STAGES-1];
      d_q    <= adc_d;
    end
  end

  assign edge_c = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign accept = edge_c & enable;

`ifdef ADC_CAPTURE_FRONTEND_TESTPAT_EN
  logic [ADC_W-1:0] ramp_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ramp_q <= '0;
    end else if (accept) begin
      ramp_q <= ramp_q + 1'b1;
    end
  end

  assign load_d  = tp_sel ? ramp_q : d_q;
  assign load_tp = tp_sel;
`else
  assign load_d  = d_q;
  assign load_tp = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q   <= '0;
      hold_vld <= 1'b0;
      hold_tp  <= 1'b0;
    end else begin
      hold_vld <= accept;
      if (accept) begin
        hold_q  <= load_d;
        hold_tp <= load_tp;
      end
    end
  end

  // Ramp samples bypass format conversion: they are always two's complement.
  always_comb begin
    src = hold_q;
    if ((fmt_e'(fmt_offset_bin) == FMT_OFFBIN) && !hold_tp) begin
      src[ADC_W-1] = ~src[ADC_W-1];
    end
    ext      = (OUT_W+1)'($signed(src));
    diff     = ext - $signed({dc_offset[OUT_W-1], dc_offset});
    clamp_hi = diff > SAT_HI;
    clamp_lo = diff < SAT_LO;
    s1_d     = diff[OUT_W-1:0];
    if (clamp_hi) begin
      s1_d = SAT_HI[OUT_W-1:0];
    end else if (clamp_lo) begin
      s1_d = SAT_LO[OUT_W-1:0];
    end
  end

  // A new clamp takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q     <= '0;
      s1_vld   <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      s1_vld <= hold_vld & enable;
      if (hold_vld) begin
        s1_q <= s1_d;
      end
      if (hold_vld && enable && (clamp_hi || clamp_lo)) begin
        sat_flag <= 1'b1;
      end else if (clear_flags) begin
        sat_flag <= 1'b0;
      end
    end
  end

  assign s1_ext = ACC_W'($signed(s1_q));
  assign sum    = acc_q + s1_ext;

  // Dropping enable empties the window so re-enabling starts a fresh one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (!enable) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else if (s1_vld) begin
        if (cnt_q == CNT_LAST) begin
          sample_out   <= OUT_W'(sum >>> AVG_LOG2);
          sample_valid <= 1'b1;
          acc_q        <= '0;
          cnt_q        <= '0;
        end else begin
          acc_q <= sum;
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/adc_capture_frontend.sv
// adc_capture_frontend: NCH-channel ADC capture front-end. Each channel is an
// independent adc_fe_channel; this level only slices the packed buses.
// Ports:
//   clk, rst (async, active-low), enable, fmt_offset_bin, clear_flags
//   adc_d [NCH*ADC_W], adc_dco [NCH], dc_offset [NCH*OUT_W]
//   sample_out [NCH*OUT_W], sample_valid [NCH], sat_flag [NCH]
//   tp_sel: present only when ADC_CAPTURE_FRONTEND_TESTPAT_EN is defined
module adc_capture_frontend
  import adc_fe_pkg::*;
#(
  parameter int unsigned NCH         = 2,
  parameter int unsigned ADC_W       = ADC_W_DEF,
  parameter int unsigned OUT_W       = OUT_W_DEF,
  parameter int unsigned AVG_LOG2    = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 fmt_offset_bin,
`ifdef ADC_CAPTURE_FRONTEND_TESTPAT_EN
  input  logic                 tp_sel,
`endif
  input  logic [NCH*ADC_W-1:0] adc_d,
  input  logic [NCH-1:0]       adc_dco,
  input  logic [NCH*OUT_W-1:0] dc_offset,
  input  logic                 clear_flags,
  output logic [NCH*OUT_W-1:0] sample_out,
  output logic [NCH-1:0]       sample_valid,
  output logic [NCH-1:0]       sat_flag
);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    adc_fe_channel #(
      .ADC_W       (ADC_W),
      .OUT_W       (OUT_W),
      .AVG_LOG2    (AVG_LOG2),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk            (clk),
      .rst            (rst),
      .enable         (enable),
      .fmt_offset_bin (fmt_offset_bin),
`ifdef ADC_CAPTURE_FRONTEND_TESTPAT_EN
      .tp_sel         (tp_sel),
`endif
      .adc_d          (adc_d[c*ADC_W +: ADC_W]),
      .adc_dco        (adc_dco[c]),
      .dc_offset      (dc_offset[c*OUT_W +: OUT_W]),
      .clear_flags    (clear_flags),
      .sample_out     (sample_out[c*OUT_W +: OUT_W]),
      .sample_valid   (sample_valid[c]),
      .sat_flag       (sat_flag[c])
    );
  end

endmodule
